// File: rtl/cbfp_pkg.sv
// cbfp_pkg: shared widths, types and per-sample helpers for the CBFP block scaler.
// Optional CBFP_ROUND_EN: round half up with saturation instead of truncation in scale().
package cbfp_pkg;

    localparam int IN_W      = 23;
    localparam int OUT_W     = 16;
    localparam int SHIFT_W   = 5;
    localparam int MAX_SHIFT = 22;
    localparam int BLK_CYC   = 4;
    localparam int LANES     = 16;
    localparam int CNT_W     = $clog2(BLK_CYC);
    localparam int DROP      = IN_W - OUT_W;

    typedef logic signed [IN_W-1:0]  sample_in_t;
    typedef logic signed [OUT_W-1:0] sample_out_t;
    typedef logic [SHIFT_W-1:0]      shift_t;

    typedef enum logic {IDLE, DRAIN} rd_state_t;

    localparam shift_t              SHIFT_CAP = SHIFT_W'(MAX_SHIFT);
    localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(BLK_CYC - 1);

`ifdef CBFP_ROUND_EN
    localparam logic signed [IN_W:0]      ROUND_HALF = (IN_W+1)'(2 ** (DROP - 1));
    localparam logic signed [IN_W-DROP:0] SAT_HI     = (IN_W-DROP+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W-DROP:0] SAT_LO     = (IN_W-DROP+1)'(-(2 ** (OUT_W - 1)));
`endif

    // Leading copies of the sign bit below the MSB; 0 and -1 saturate at MAX_SHIFT.
    function automatic shift_t rsb(input sample_in_t x);
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = IN_W - 2; i >= 0; i--) begin
            run = run & (x[i] == x[IN_W-1]);
            n   = n + int'(run);
        end
        return (n > MAX_SHIFT) ? SHIFT_CAP : SHIFT_W'(n);
    endfunction

    // Normalize by the block shift, then drop DROP LSBs (rounded or truncated).
    function automatic sample_out_t scale(input sample_in_t x, input shift_t s);
        sample_in_t sh;
`ifdef CBFP_ROUND_EN
        logic signed [IN_W:0]      r;
        logic signed [IN_W-DROP:0] q;
`endif
        sh = x <<< s;
`ifdef CBFP_ROUND_EN
        r = {sh[IN_W-1], sh};
        r = r + ROUND_HALF;
        q = r[IN_W:DROP];
        return (q > SAT_HI) ? SAT_HI[OUT_W-1:0] : (q < SAT_LO) ? SAT_LO[OUT_W-1:0] : q[OUT_W-1:0];
`else
        return sh[IN_W-1:DROP];
`endif
    endfunction

endpackage

// File: rtl/cbfp_rsb_min.sv
// cbfp_rsb_min: per-lane redundant-sign-bit count reduced to the beat minimum, capped at MAX_SHIFT.
module cbfp_rsb_min
    import cbfp_pkg::*;
(
    input  logic [LANES-1:0][IN_W-1:0] data,
    output shift_t                     min_shift
);

    // Binary min tree over the lane RSBs; leaves sit at LANES-1..2*LANES-2.
    always_comb begin : tree
        shift_t node [2*LANES-1];
        for (int i = 0; i < LANES; i++) node[LANES-1+i] = rsb(data[i]);
        for (int i = LANES - 2; i >= 0; i--) node[i] = (node[2*i+1] < node[2*i+2]) ? node[2*i+1] : node[2*i+2];
        min_shift = (node[0] > SHIFT_CAP) ? SHIFT_CAP : node[0];
    end

endmodule

// File: rtl/cbfp_block_scaler.sv
// cbfp_block_scaler: ping-pong block buffer applying a common per-block CBFP shift to re and im.
// Optional CBFP_ROUND_EN (see cbfp_pkg::scale): round half up with saturation.
module cbfp_block_scaler
    import cbfp_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_in,
    input  logic [LANES-1:0][IN_W-1:0]     data_re_in,
    input  logic [LANES-1:0][IN_W-1:0]     data_im_in,
    output logic [LANES-1:0][OUT_W-1:0]    data_re_out,
    output logic [LANES-1:0][OUT_W-1:0]    data_im_out,
    output logic [LANES-1:0][SHIFT_W-1:0]  index_re_out,
    output logic [LANES-1:0][SHIFT_W-1:0]  index_im_out,
    output logic                           block_start,
    output logic                           valid_out
);

    logic [LANES-1:0][IN_W-1:0] mem_re [2][BLK_CYC];
    logic [LANES-1:0][IN_W-1:0] mem_im [2][BLK_CYC];
    logic [CNT_W-1:0]           wr_cnt, rd_cnt;
    logic                       wr_bank, rd_bank;
    logic [1:0]                 full;
    shift_t                     min_re, min_im, beat_re, beat_im, blk_re, blk_im;
    shift_t                     sh_re [2];
    shift_t                     sh_im [2];
    rd_state_t                  state, state_nxt;
    logic                       wr_last, rd_en, rd_last;

    cbfp_rsb_min u_rsb_re (.data(data_re_in), .min_shift(beat_re));
    cbfp_rsb_min u_rsb_im (.data(data_im_in), .min_shift(beat_im));

    // Running block minimum including the current beat, and the block-closing beat flag.
    always_comb begin
        blk_re  = (beat_re < min_re) ? beat_re : min_re;
        blk_im  = (beat_im < min_im) ? beat_im : min_im;
        wr_last = valid_in && (wr_cnt == LAST_BEAT);
    end

    // Sample storage; contents need no reset because the full flags gate every read.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            mem_re[wr_bank][wr_cnt] <= data_re_in;
            mem_im[wr_bank][wr_cnt] <= data_im_in;
        end
    end

    // Write side: beat counter, running minima and per-bank shift capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            min_re  <= SHIFT_CAP;
            min_im  <= SHIFT_CAP;
            sh_re   <= '{default: '0};
            sh_im   <= '{default: '0};
        end else if (wr_last) begin
            sh_re[wr_bank] <= blk_re;
            sh_im[wr_bank] <= blk_im;
            wr_bank        <= ~wr_bank;
            wr_cnt         <= '0;
            min_re         <= SHIFT_CAP;
            min_im         <= SHIFT_CAP;
        end else if (valid_in) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
            min_re <= blk_re;
            min_im <= blk_im;
        end
    end

    // Bank occupancy: set when the writer closes a block, cleared after its last read beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            if (rd_last) full[rd_bank] <= 1'b0;
            if (wr_last) full[wr_bank] <= 1'b1;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Read FSM next state: chain straight into the other bank when it is already full.
    always_comb begin
        state_nxt = (state == IDLE) ? (full[rd_bank] ? DRAIN : IDLE)
                                    : (rd_last ? (full[~rd_bank] ? DRAIN : IDLE) : DRAIN);
    end

    // Read FSM outputs.
    always_comb begin
        rd_en   = (state == DRAIN);
        rd_last = rd_en && (rd_cnt == LAST_BEAT);
    end

    // Read pointer: beat counter and bank toggle at the end of each drained block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else if (rd_en) begin
            rd_cnt  <= rd_last ? '0 : rd_cnt + CNT_W'(1);
            rd_bank <= rd_bank ^ rd_last;
        end
    end

    // Registered outputs: scaled samples and the shift indices of the block being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_re_out  <= '0;
            data_im_out  <= '0;
            index_re_out <= '0;
            index_im_out <= '0;
            block_start  <= 1'b0;
            valid_out    <= 1'b0;
        end else begin
            valid_out   <= rd_en;
            block_start <= rd_en && (rd_cnt == '0);
            if (rd_en) begin
                for (int i = 0; i < LANES; i++) begin
                    data_re_out[i] <= scale(mem_re[rd_bank][rd_cnt][i], sh_re[rd_bank]);
                    data_im_out[i] <= scale(mem_im[rd_bank][rd_cnt][i], sh_im[rd_bank]);
                end
                index_re_out <= {LANES{sh_re[rd_bank]}};
                index_im_out <= {LANES{sh_im[rd_bank]}};
            end
        end
    end

endmodule

// File: tb/tb_cbfp_block_scaler.sv
// tb_cbfp_block_scaler: scoreboard bench for the CBFP block scaler (either CBFP_ROUND_EN build).
module tb_cbfp_block_scaler;
    import cbfp_pkg::*;

    typedef logic [LANES-1:0][IN_W-1:0]    vin_t;
    typedef logic [LANES-1:0][OUT_W-1:0]   vout_t;
    typedef logic [LANES-1:0][SHIFT_W-1:0] vidx_t;
    typedef struct {
        int    cyc;
        vout_t re;
        vout_t im;
        int    sr;
        int    si;
        bit    start;
        bit    last;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  valid_in = 1'b0;
    vin_t  data_re_in = '0, data_im_in = '0;
    vout_t data_re_out, data_im_out;
    vidx_t index_re_out, index_im_out;
    logic  block_start, valid_out;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   errs = 0;
    int   wr_blocks = 0;
    int   rd_blocks = 0;

    cbfp_block_scaler dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .data_re_in(data_re_in), .data_im_in(data_im_in),
        .data_re_out(data_re_out), .data_im_out(data_im_out),
        .index_re_out(index_re_out), .index_im_out(index_im_out),
        .block_start(block_start), .valid_out(valid_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sext(input logic [IN_W-1:0] v);
        return longint'($signed(v));
    endfunction

    // Largest k <= MAX_SHIFT such that x * 2^k still fits in IN_W signed bits.
    function automatic int rsb_m(input longint x);
        longint lim;
        int     k;
        lim = longint'(1) << (IN_W - 1);
        k   = 0;
        while (k < MAX_SHIFT && x * (longint'(1) << (k + 1)) < lim && x * (longint'(1) << (k + 1)) >= -lim) k++;
        return k;
    endfunction

    function automatic logic [OUT_W-1:0] scale_m(input longint x, input int s);
        longint v, q;
        v = x * (longint'(1) << s);
`ifdef CBFP_ROUND_EN
        q = (v + 64'sd64) >>> (IN_W - OUT_W);
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
`else
        q = v >>> (IN_W - OUT_W);
`endif
        return q[OUT_W-1:0];
    endfunction

    // Drives one block (with per-beat trailing idle gaps) and queues its expected output beats.
    task automatic send_block(input vin_t re [BLK_CYC], input vin_t im [BLK_CYC], input int gap [BLK_CYC]);
        int   mr, mi, t;
        exp_t e;
        mr = MAX_SHIFT;
        mi = MAX_SHIFT;
        for (int b = 0; b < BLK_CYC; b++)
            for (int l = 0; l < LANES; l++) begin
                if (rsb_m(sext(re[b][l])) < mr) mr = rsb_m(sext(re[b][l]));
                if (rsb_m(sext(im[b][l])) < mi) mi = rsb_m(sext(im[b][l]));
            end
        vectors++;
        if (wr_blocks - rd_blocks > 2) begin
            errs++;
            $display("FAIL bank_overflow: %0d blocks held, required <= 2", wr_blocks - rd_blocks);
        end
        for (int b = 0; b < BLK_CYC; b++) begin
            @(negedge clk);
            valid_in   = 1'b1;
            data_re_in = re[b];
            data_im_in = im[b];
            if (b == BLK_CYC - 1) begin
                t = cyc + 1;
                for (int k = 0; k < BLK_CYC; k++) begin
                    e.cyc = t + 2 + k;
                    e.sr = mr;
                    e.si = mi;
                    e.start = (k == 0);
                    e.last = (k == BLK_CYC - 1);
                    for (int l = 0; l < LANES; l++) begin
                        e.re[l] = scale_m(sext(re[k][l]), mr);
                        e.im[l] = scale_m(sext(im[k][l]), mi);
                    end
                    sb.push_back(e);
                end
            end
            for (int g = 0; g < gap[b]; g++) begin
                @(negedge clk);
                valid_in = 1'b0;
            end
        end
        wr_blocks++;
    endtask

    // Scoreboard monitor: every valid output beat must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t  e;
        vidx_t ir, ii;
        if (rst_n && valid_out) begin
            vectors++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL unexpected_beat: valid_out=1 at cycle %0d, required no output", cyc);
            end else begin
                e = sb.pop_front();
                for (int l = 0; l < LANES; l++) begin
                    ir[l] = SHIFT_W'(e.sr);
                    ii[l] = SHIFT_W'(e.si);
                end
                vectors += 5;
                if (cyc !== e.cyc) begin
                    errs++;
                    $display("FAIL beat_cycle: got %0d required %0d", cyc, e.cyc);
                end
                if (data_re_out !== e.re) begin
                    errs++;
                    $display("FAIL data_re: got %h required %h", data_re_out, e.re);
                end
                if (data_im_out !== e.im) begin
                    errs++;
                    $display("FAIL data_im: got %h required %h", data_im_out, e.im);
                end
                if (index_re_out !== ir || index_im_out !== ii) begin
                    errs++;
                    $display("FAIL index: got re %h im %h required re %h im %h", index_re_out, index_im_out, ir, ii);
                end
                if (block_start !== e.start) begin
                    errs++;
                    $display("FAIL block_start: got %b required %b at cycle %0d", block_start, e.start, cyc);
                end
                if (e.last) rd_blocks++;
            end
        end else if (rst_n && block_start) begin
            vectors++;
            errs++;
            $display("FAIL block_start_idle: got 1 required 0 at cycle %0d", cyc);
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors += 3;
        if (valid_out !== 1'b0 || block_start !== 1'b0) begin
            errs++;
            $display("FAIL reset_ctrl: valid_out=%b block_start=%b required 0 0", valid_out, block_start);
        end
        if (data_re_out !== '0 || data_im_out !== '0) begin
            errs++;
            $display("FAIL reset_data: re=%h im=%h required 0", data_re_out, data_im_out);
        end
        if (index_re_out !== '0 || index_im_out !== '0) begin
            errs++;
            $display("FAIL reset_index: re=%h im=%h required 0", index_re_out, index_im_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic finish_drain(input string name);
        @(negedge clk);
        valid_in = 1'b0;
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL drain_%s: %0d beats outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_basic();
        vin_t re [BLK_CYC], im [BLK_CYC];
        int   gap [BLK_CYC];
        for (int b = 0; b < BLK_CYC; b++) begin
            for (int l = 0; l < LANES; l++) begin
                re[b][l] = 23'd1;
                im[b][l] = 23'd0;
            end
            gap[b] = 0;
        end
        send_block(re, im, gap);
        finish_drain("basic");
    endtask

    task automatic test_saturate();
        vin_t re [BLK_CYC], im [BLK_CYC];
        int   gap [BLK_CYC];
        for (int b = 0; b < BLK_CYC; b++) begin
            for (int l = 0; l < LANES; l++) begin
                re[b][l] = 23'd1;
                im[b][l] = IN_W'(l * 3 - 20);
            end
            gap[b] = 0;
        end
        re[2][5] = 23'h3FFFFF;
        send_block(re, im, gap);
        finish_drain("saturate");
    endtask

    task automatic test_negative();
        vin_t re [BLK_CYC], im [BLK_CYC];
        int   gap [BLK_CYC];
        for (int b = 0; b < BLK_CYC; b++) begin
            for (int l = 0; l < LANES; l++) begin
                re[b][l] = '1;
                im[b][l] = IN_W'(b * 100 + l);
            end
            gap[b] = 0;
        end
        send_block(re, im, gap);
        for (int b = 0; b < BLK_CYC; b++)
            for (int l = 0; l < LANES; l++) begin
                re[b][l] = 23'h400000;
                im[b][l] = '1;
            end
        send_block(re, im, gap);
        finish_drain("negative");
    endtask

    task automatic rand_block(output vin_t re [BLK_CYC], output vin_t im [BLK_CYC], input int s);
        logic signed [IN_W-1:0] t;
        for (int b = 0; b < BLK_CYC; b++)
            for (int l = 0; l < LANES; l++) begin
                t = IN_W'($urandom);
                re[b][l] = t >>> s;
                t = IN_W'($urandom);
                im[b][l] = t >>> ((s + 4) % 20);
            end
    endtask

    task automatic test_idle_gaps();
        vin_t re [BLK_CYC], im [BLK_CYC];
        int   gap [BLK_CYC];
        gap = '{1, 3, 2, 0};
        rand_block(re, im, 9);
        send_block(re, im, gap);
        finish_drain("idle_gaps");
    endtask

    task automatic test_back_to_back();
        vin_t re [BLK_CYC], im [BLK_CYC];
        int   gap [BLK_CYC];
        int   sh [3];
        gap = '{0, 0, 0, 0};
        sh = '{3, 12, 18};
        for (int k = 0; k < 3; k++) begin
            rand_block(re, im, sh[k]);
            send_block(re, im, gap);
        end
        finish_drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        vin_t re [BLK_CYC], im [BLK_CYC];
        int   gap [BLK_CYC];
        gap = '{0, 0, 0, 0};
        rand_block(re, im, 5);
        send_block(re, im, gap);
        rand_block(re, im, 2);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            valid_in   = 1'b1;
            data_re_in = re[b];
            data_im_in = im[b];
        end
        @(posedge clk);
        #2;
        vectors++;
        if (valid_out !== 1'b1) begin
            errs++;
            $display("FAIL pre_reset_active: valid_out=%b required 1", valid_out);
        end
        rst_n    = 1'b0;
        valid_in = 1'b0;
        #1;
        vectors++;
        if (valid_out !== 1'b0) begin
            errs++;
            $display("FAIL async_reset_drop: valid_out=%b required 0", valid_out);
        end
        sb.delete();
        wr_blocks = 0;
        rd_blocks = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rand_block(re, im, 14);
        send_block(re, im, gap);
        finish_drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_negative();
        test_idle_gaps();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d beats outstanding", sb.size());
        $fatal(1, "watchdog");
    end

endmodule
